control_unit: RTL and testbench

- Hardwired control sequencer for the 32-bit datapath.
- Generates the per-step control strobes that drive `DataPath`: fetch (T0–T2), then a decode/execute sequence (T3–T5) selected by the IR opcode.
- It drives the datapath control inputs; it is the counterpart to the datapath, which consumes them.
- Supported opcodes: add, sub, and, or, addi, andi, ori, nop, halt. Handles memory-read wait states.

---
 rtl/control_unit_pkg.sv | 55 +++++
 rtl/control_unit_if.sv | 27 ++
 rtl/control_unit_opdecode.sv | 30 +++
 rtl/control_unit.sv | 149 ++++++++++++++
 tb/tb_control_unit.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/control_unit_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, FSM states,
// IR field positions and the decoder's result types.
package cpu_ctrl_pkg;

    localparam int OPW = 5;
    localparam int IRW = 32;

    // IR field positions
    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;

    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        T0     = 4'd1,
        T1     = 4'd2,
        T2     = 4'd3,
        T3     = 4'd4,
        T4     = 4'd5,
        T5     = 4'd6,
        S_HALT = 4'd7,
        S_WAIT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_REG,
        CLS_IMM,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    typedef struct packed {
        logic add_sel;
        logic sub_sel;
        logic and_sel;
        logic or_sel;
    } alu_sel_t;

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath signal bundle. master = control unit (drives strobes),
// slave = datapath (supplies IR contents and memory-ready).
interface control_unit_if #(
    parameter int IRW = 32
);
    logic [IRW-1:0] ir;
    logic           mem_ready;

    logic PCout, PCin, IncPC, MARin, Read, MD_read, MDRin, MDRout, IRin;
    logic Yin, Zlowin, Zlowout, Gra, Grb, Grc, Rin, Rout, BAout, Csignout;
    logic ADD, SUB, AND, OR;
    logic run, illegal;

    modport master (
        input  ir, mem_ready,
        output PCout, PCin, IncPC, MARin, Read, MD_read, MDRin, MDRout, IRin,
        output Yin, Zlowin, Zlowout, Gra, Grb, Grc, Rin, Rout, BAout, Csignout,
        output ADD, SUB, AND, OR, run, illegal
    );

    modport slave (
        output ir, mem_ready,
        input  PCout, PCin, IncPC, MARin, Read, MD_read, MDRin, MDRout, IRin,
        input  Yin, Zlowin, Zlowout, Gra, Grb, Grc, Rin, Rout, BAout, Csignout,
        input  ADD, SUB, AND, OR, run, illegal
    );
endinterface

// File: rtl/control_unit_opdecode.sv
// Opcode classifier: maps ir[31:27] to an instruction class and a one-hot ALU select.
module ctrl_opdecode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] opcode,
    output op_class_t      op_class,
    output alu_sel_t       alu_sel
);

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        op_class = CLS_ILLEGAL;
        alu_sel  = '0;
        unique case (opcode)
            OP_ADD:  begin op_class = CLS_REG; alu_sel.add_sel = 1'b1; end
            OP_SUB:  begin op_class = CLS_REG; alu_sel.sub_sel = 1'b1; end
            OP_AND:  begin op_class = CLS_REG; alu_sel.and_sel = 1'b1; end
            OP_OR:   begin op_class = CLS_REG; alu_sel.or_sel  = 1'b1; end
            OP_ADDI: begin op_class = CLS_IMM; alu_sel.add_sel = 1'b1; end
            OP_ANDI: begin op_class = CLS_IMM; alu_sel.and_sel = 1'b1; end
            OP_ORI:  begin op_class = CLS_IMM; alu_sel.or_sel  = 1'b1; end
            OP_NOP:  op_class = CLS_NOP;
            OP_HALT: op_class = CLS_HALT;
            default: op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch T0-T2, opcode-selected execute T3-T5.
// Optional CTRL_SINGLE_STEP_EN adds a step input and parks in S_WAIT between instructions.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW = 5,
    parameter int IRW = 32
) (
    input  logic clock,
    input  logic clear,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic step,
`endif
    control_unit_if.master bus
);

`ifdef CTRL_SINGLE_STEP_EN
    localparam state_t S_NEXT_INSN = S_WAIT;
`else
    localparam state_t S_NEXT_INSN = T0;
`endif

    state_t         state, state_next;
    logic           illegal_q;
    logic [OPW-1:0] opcode;
    op_class_t      op_class;
    alu_sel_t       alu_sel;

    assign opcode = bus.ir[IRW-1 -: OPW];

    ctrl_opdecode #(.OPW(OPW)) u_opdecode (
        .opcode   (opcode),
        .op_class (op_class),
        .alu_sel  (alu_sel)
    );

    // NOTE: sequential state uses non-blocking assignments under an async active-low clear.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state     <= S_RST;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == T3 && op_class == CLS_ILLEGAL) illegal_q <= 1'b1;
        end
    end

    assign bus.illegal = illegal_q;

    always_comb begin
        state_next   = state;
        bus.PCout    = 1'b0;
        bus.PCin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.MARin    = 1'b0;
        bus.Read     = 1'b0;
        bus.MD_read  = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zlowin   = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Gra      = 1'b0;
        bus.Grb      = 1'b0;
        bus.Grc      = 1'b0;
        bus.Rin      = 1'b0;
        bus.Rout     = 1'b0;
        bus.BAout    = 1'b0;
        bus.Csignout = 1'b0;
        bus.ADD      = 1'b0;
        bus.SUB      = 1'b0;
        bus.AND      = 1'b0;
        bus.OR       = 1'b0;
        bus.run      = 1'b0;

        case (state)
            S_RST: state_next = T0;
            T0: begin
                bus.run    = 1'b1;
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zlowin = 1'b1;
                state_next = T1;
            end
            T1: begin
                bus.run     = 1'b1;
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MD_read = 1'b1;
                bus.MDRin   = 1'b1;
                if (bus.mem_ready) state_next = T2;
            end
            T2: begin
                bus.run    = 1'b1;
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_next = T3;
            end
            T3: begin
                bus.run = 1'b1;
                case (op_class)
                    CLS_REG, CLS_IMM: begin
                        // addi sources the base through BAout so that R0 reads as zero
                        bus.Grb    = 1'b1;
                        bus.Yin    = 1'b1;
                        bus.BAout  = (opcode == OP_ADDI);
                        bus.Rout   = (opcode != OP_ADDI);
                        state_next = T4;
                    end
                    CLS_NOP: state_next = S_NEXT_INSN;
                    default: state_next = S_HALT;
                endcase
            end
            T4: begin
                bus.run      = 1'b1;
                bus.Zlowin   = 1'b1;
                bus.Grc      = (op_class == CLS_REG);
                bus.Rout     = (op_class == CLS_REG);
                bus.Csignout = (op_class == CLS_IMM);
                bus.ADD      = alu_sel.add_sel;
                bus.SUB      = alu_sel.sub_sel;
                bus.AND      = alu_sel.and_sel;
                bus.OR       = alu_sel.or_sel;
                state_next   = T5;
            end
            T5: begin
                bus.run     = 1'b1;
                bus.Zlowout = 1'b1;
                bus.Gra     = 1'b1;
                bus.Rin     = 1'b1;
                state_next  = S_NEXT_INSN;
            end
            S_HALT: state_next = S_HALT;
            S_WAIT: begin
                bus.run = 1'b1;
`ifdef CTRL_SINGLE_STEP_EN
                if (step) state_next = T0;
`else
                state_next = T0;
`endif
            end
            default: state_next = S_RST;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; per-cycle bus-exclusivity and
// ALU one-hot monitors run alongside the instruction vectors.
module tb_control_unit;

    logic clock;
    logic clear;
`ifdef CTRL_SINGLE_STEP_EN
    logic step;
`endif

    control_unit_if #(.IRW(32)) bus ();

    control_unit #(.OPW(5), .IRW(32)) dut (
        .clock (clock),
        .clear (clear),
`ifdef CTRL_SINGLE_STEP_EN
        .step  (step),
`endif
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observed strobe vector, MSB first
    localparam logic [22:0] PCOUT    = 23'h1 << 22;
    localparam logic [22:0] PCIN     = 23'h1 << 21;
    localparam logic [22:0] INCPC    = 23'h1 << 20;
    localparam logic [22:0] MARIN    = 23'h1 << 19;
    localparam logic [22:0] READ     = 23'h1 << 18;
    localparam logic [22:0] MDREAD   = 23'h1 << 17;
    localparam logic [22:0] MDRIN    = 23'h1 << 16;
    localparam logic [22:0] MDROUT   = 23'h1 << 15;
    localparam logic [22:0] IRIN     = 23'h1 << 14;
    localparam logic [22:0] YIN      = 23'h1 << 13;
    localparam logic [22:0] ZLOWIN   = 23'h1 << 12;
    localparam logic [22:0] ZLOWOUT  = 23'h1 << 11;
    localparam logic [22:0] GRA      = 23'h1 << 10;
    localparam logic [22:0] GRB      = 23'h1 << 9;
    localparam logic [22:0] GRC      = 23'h1 << 8;
    localparam logic [22:0] RIN      = 23'h1 << 7;
    localparam logic [22:0] ROUT     = 23'h1 << 6;
    localparam logic [22:0] BAOUT    = 23'h1 << 5;
    localparam logic [22:0] CSIGNOUT = 23'h1 << 4;
    localparam logic [22:0] ALU_ADD  = 23'h1 << 3;
    localparam logic [22:0] ALU_SUB  = 23'h1 << 2;
    localparam logic [22:0] ALU_AND  = 23'h1 << 1;
    localparam logic [22:0] ALU_OR   = 23'h1 << 0;

    localparam logic [22:0] E_T0 = PCOUT | MARIN | INCPC | ZLOWIN;
    localparam logic [22:0] E_T1 = ZLOWOUT | PCIN | READ | MDREAD | MDRIN;
    localparam logic [22:0] E_T2 = MDROUT | IRIN;
    localparam logic [22:0] E_T5 = ZLOWOUT | GRA | RIN;
    localparam logic [22:0] E_T3_REG = GRB | ROUT | YIN;
    localparam logic [22:0] E_T3_ADDI = GRB | BAOUT | YIN;
    localparam logic [22:0] E_T4_REG = GRC | ROUT | ZLOWIN;
    localparam logic [22:0] E_T4_IMM = CSIGNOUT | ZLOWIN;

    logic [22:0] obs;
    assign obs = {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.Read, bus.MD_read,
                  bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.Zlowin, bus.Zlowout,
                  bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.Csignout,
                  bus.ADD, bus.SUB, bus.AND, bus.OR};

    logic [5:0] bus_drv;
    logic [3:0] alu_drv;
    assign bus_drv = {bus.PCout, bus.Zlowout, bus.MDRout, bus.Rout, bus.BAout, bus.Csignout};
    assign alu_drv = {bus.ADD, bus.SUB, bus.AND, bus.OR};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (clear) begin
            check("bus_exclusive", 32'($countones(bus_drv) <= 1), 32'd1);
            check("alu_onehot", 32'($countones(alu_drv) <= 1), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // From T5 (or nop T3) sampled, advance to the next T0 sampled.
    task automatic insn_gap();
`ifdef CTRL_SINGLE_STEP_EN
        tick();
        check("wait_strobes", 32'(obs), 32'd0);
        check("wait_run", 32'(bus.run), 32'd1);
        tick();
        check("wait_parked", 32'(obs), 32'd0);
        step = 1'b1;
        tick();
        step = 1'b0;
`else
        tick();
`endif
    endtask

    // Called with T0 sampled; returns with the following T0 sampled.
    task automatic run_insn(input string tag, input logic [31:0] ir_val,
                            input logic [22:0] e3, input logic [22:0] e4, input int stall);
        int cycles;
        bus.ir = ir_val;
        check({tag, "_t0"}, 32'(obs), 32'(E_T0));
        check({tag, "_run"}, 32'(bus.run), 32'd1);
        bus.mem_ready = (stall == 0);
        tick(); cycles = 1;
        for (int i = 0; i < stall; i++) begin
            check({tag, "_t1_stall"}, 32'(obs), 32'(E_T1));
            tick(); cycles++;
        end
        bus.mem_ready = 1'b1;
        check({tag, "_t1"}, 32'(obs), 32'(E_T1));
        tick(); cycles++;
        check({tag, "_t2"}, 32'(obs), 32'(E_T2));
        tick(); cycles++;
        check({tag, "_t3"}, 32'(obs), 32'(e3));
        tick(); cycles++;
        check({tag, "_t4"}, 32'(obs), 32'(e4));
        tick(); cycles++;
        check({tag, "_t5"}, 32'(obs), 32'(E_T5));
        insn_gap(); cycles++;
        check({tag, "_latency"}, 32'(cycles), 32'(6 + stall));
        check({tag, "_next_t0"}, 32'(obs), 32'(E_T0));
    endtask

    // Fetch through T3 for opcodes with no execute strobes; leaves T3 sampled.
    task automatic fetch_to_t3(input string tag, input logic [31:0] ir_val);
        bus.ir = ir_val;
        bus.mem_ready = 1'b1;
        check({tag, "_t0"}, 32'(obs), 32'(E_T0));
        tick();
        check({tag, "_t1"}, 32'(obs), 32'(E_T1));
        tick();
        check({tag, "_t2"}, 32'(obs), 32'(E_T2));
        tick();
        check({tag, "_t3"}, 32'(obs), 32'd0);
        check({tag, "_t3_run"}, 32'(bus.run), 32'd1);
    endtask

    task automatic pulse_clear_and_restart(input string tag);
        clear = 1'b0;
        #1;
        check({tag, "_rst_strobes"}, 32'(obs), 32'd0);
        check({tag, "_rst_run"}, 32'(bus.run), 32'd0);
        check({tag, "_rst_illegal"}, 32'(bus.illegal), 32'd0);
        #2;
        clear = 1'b1;
        tick();
        check({tag, "_restart_t0"}, 32'(obs), 32'(E_T0));
    endtask

    initial begin
        clear = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
        step = 1'b0;
`endif
        bus.ir = 32'h6100_0005;
        bus.mem_ready = 1'b1;
        #12;
        check("reset_strobes", 32'(obs), 32'd0);
        check("reset_run", 32'(bus.run), 32'd0);
        check("reset_illegal", 32'(bus.illegal), 32'd0);
        clear = 1'b1;
        tick();

        run_insn("addi", 32'h6100_0005, E_T3_ADDI, E_T4_IMM | ALU_ADD, 0);
        run_insn("add", 32'h1891_8000, E_T3_REG, E_T4_REG | ALU_ADD, 0);
        run_insn("andi", 32'h6900_0000, E_T3_REG, E_T4_IMM | ALU_AND, 0);
        run_insn("sub", 32'h2000_0000, E_T3_REG, E_T4_REG | ALU_SUB, 0);
        run_insn("or", 32'h3000_0000, E_T3_REG, E_T4_REG | ALU_OR, 0);
        run_insn("ori", 32'h7000_0000, E_T3_REG, E_T4_IMM | ALU_OR, 0);
        run_insn("stall", 32'h1891_8000, E_T3_REG, E_T4_REG | ALU_ADD, 3);

        // nop: T0..T3 then straight on to the next instruction
        fetch_to_t3("nop", 32'hD000_0000);
        insn_gap();
        check("nop_next_t0", 32'(obs), 32'(E_T0));

        fetch_to_t3("halt", 32'hD800_0000);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("halt_strobes", 32'(obs), 32'd0);
            check("halt_run", 32'(bus.run), 32'd0);
            check("halt_illegal", 32'(bus.illegal), 32'd0);
        end
        pulse_clear_and_restart("after_halt");

        fetch_to_t3("illegal", 32'hF800_0000);
        tick();
        check("illegal_flag", 32'(bus.illegal), 32'd1);
        check("illegal_run", 32'(bus.run), 32'd0);
        check("illegal_strobes", 32'(obs), 32'd0);
        tick();
        check("illegal_sticky", 32'(bus.illegal), 32'd1);
        pulse_clear_and_restart("after_illegal");

        // Reset asserted while sitting in T4
        bus.ir = 32'h1891_8000;
        tick(); tick(); tick(); tick();
        check("mid_t4", 32'(obs), 32'(E_T4_REG | ALU_ADD));
        pulse_clear_and_restart("mid_insn");

        run_insn("post_reset_add", 32'h1891_8000, E_T3_REG, E_T4_REG | ALU_ADD, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
